// File: rtl/fake_n64_frame_rx.sv
// N64 console-to-controller frame receiver. The bit decoder is timed by counters on the
// system clock. It captures cmd/address, streams the WRITE payload to RAM and checks CRC-8.
module fake_n64_frame_rx #(
   parameter int         CLKS_PER_US   = 50,
   parameter int         PAYLOAD_BYTES = 32,
   parameter logic [7:0] CRC_POLY      = 8'h85,
   localparam int        AW            = (PAYLOAD_BYTES > 1) ? $clog2(PAYLOAD_BYTES) : 1
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          rx_enable,
   input  logic          data_rx,
   output logic          busy,
   output logic          frame_valid,
   output logic          frame_err,
   output logic [7:0]    cmd,
   output logic [15:0]   address,
   output logic [7:0]    crc,
   output logic          crc_ok,
   output logic          wr_en,
   output logic [AW-1:0] wr_addr,
   output logic [7:0]    wr_data
);

   localparam int TW       = $clog2(5 * CLKS_PER_US);
   localparam int PAY_BITS = 8 * PAYLOAD_BYTES;
   localparam int BCW      = $clog2(26 + PAY_BITS + 1);

   localparam logic [TW-1:0]  SAMPLE_AT  = TW'(2 * CLKS_PER_US - 1);
   localparam logic [TW-1:0]  TIMEOUT_AT = TW'(5 * CLKS_PER_US - 1);
   localparam logic [BCW-1:0] BITS_SAT   = BCW'(26 + PAY_BITS);
   localparam logic [BCW-1:0] CMD_END    = BCW'(8);
   localparam logic [BCW-1:0] ADDR_END   = BCW'(24);
   localparam logic [BCW-1:0] PAY_END    = BCW'(24 + PAY_BITS);
   localparam logic [BCW-1:0] LEN_SHORT  = BCW'(9);
   localparam logic [BCW-1:0] LEN_READ   = BCW'(25);
   localparam logic [BCW-1:0] LEN_WRITE  = BCW'(25 + PAY_BITS);

   typedef enum logic [1:0] {IDLE, BIT, EVAL} state_t;

   state_t         state_reg, state_next;
   logic           sync_meta, sync_cur, sync_prev;
   logic [TW-1:0]  tcnt;
   logic [BCW-1:0] bitcnt;
   logic [7:0]     cmd_sr;
   logic [15:0]    addr_sr;
   logic [6:0]     byte_sr;
   logic [7:0]     crc_sr;
   logic [AW-1:0]  pay_byte;

   logic           fell;
   logic           in_bit;
   logic           take_bit;
   logic           end_frame;
   logic           start_frame;
   logic           in_payload;
   logic           byte_done;
   logic           frame_good;
   logic [7:0]     crc_step;

   assign busy        = (state_reg != IDLE);
   assign fell        = sync_prev & ~sync_cur;
   assign in_bit      = (state_reg == BIT) && rx_enable;
   assign take_bit    = in_bit && (tcnt == SAMPLE_AT) && (bitcnt < BITS_SAT);
   assign end_frame   = in_bit && !fell && (tcnt == TIMEOUT_AT);
   assign start_frame = (state_reg == IDLE) && rx_enable && fell;
   assign in_payload  = (bitcnt >= ADDR_END) && (bitcnt < PAY_END);
   // 24 is a multiple of 8, so the payload bit-in-byte position is just bitcnt[2:0]
   assign byte_done   = (bitcnt[2:0] == 3'd7);
   assign crc_step    = {crc_sr[6:0], 1'b0} ^ ((crc_sr[7] ^ sync_cur) ? CRC_POLY : 8'h00);

   always_comb begin
      frame_good = 1'b0;
      case (cmd_sr)
         8'h00, 8'h01, 8'hFF: frame_good = (bitcnt == LEN_SHORT);
         8'h02:               frame_good = (bitcnt == LEN_READ);
         8'h03:               frame_good = (bitcnt == LEN_WRITE);
         default:             frame_good = 1'b0;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_reg <= IDLE;
      else          state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (!rx_enable) begin
         state_next = IDLE;
      end else begin
         case (state_reg)
            IDLE:    if (fell) state_next = BIT;
            BIT:     if (!fell && tcnt == TIMEOUT_AT) state_next = EVAL;
            EVAL:    state_next = IDLE;
            default: state_next = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync_meta   <= 1'b1;
         sync_cur    <= 1'b1;
         sync_prev   <= 1'b1;
         tcnt        <= '0;
         bitcnt      <= '0;
         cmd_sr      <= '0;
         addr_sr     <= '0;
         byte_sr     <= '0;
         crc_sr      <= '0;
         pay_byte    <= '0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;
         cmd         <= '0;
         address     <= '0;
         crc         <= '0;
         crc_ok      <= 1'b0;
         wr_en       <= 1'b0;
         wr_addr     <= '0;
         wr_data     <= '0;
      end else begin
         sync_meta   <= data_rx;
         sync_cur    <= sync_meta;
         sync_prev   <= sync_cur;
         wr_en       <= 1'b0;
         frame_valid <= 1'b0;
         frame_err   <= 1'b0;

         if (start_frame) begin
            tcnt     <= '0;
            bitcnt   <= '0;
            cmd_sr   <= '0;
            addr_sr  <= '0;
            byte_sr  <= '0;
            crc_sr   <= '0;
            pay_byte <= '0;
         end else if (in_bit) begin
            if (fell)
               tcnt <= '0;
            else if (tcnt != TIMEOUT_AT)
               tcnt <= tcnt + 1'b1;

            if (take_bit) begin
               bitcnt <= bitcnt + 1'b1;
               if (bitcnt < CMD_END) begin
                  cmd_sr <= {cmd_sr[6:0], sync_cur};
               end else if (bitcnt < ADDR_END) begin
                  addr_sr <= {addr_sr[14:0], sync_cur};
               end else if (in_payload) begin
                  // The stop bit of a full WRITE lands beyond PAY_END, so it never
                  // reaches the CRC or completes a byte.
                  byte_sr <= {byte_sr[5:0], sync_cur};
                  crc_sr  <= crc_step;
                  if (byte_done) begin
                     pay_byte <= pay_byte + 1'b1;
                     if (cmd_sr == 8'h03) begin
                        wr_en   <= 1'b1;
                        wr_addr <= pay_byte;
                        wr_data <= {byte_sr, sync_cur};
                     end
                  end
               end
            end

            if (end_frame) begin
               if (frame_good) begin
                  frame_valid <= 1'b1;
                  cmd         <= cmd_sr;
                  if (cmd_sr == 8'h02 || cmd_sr == 8'h03)
                     address <= addr_sr;
                  if (cmd_sr == 8'h03) begin
                     crc    <= crc_sr;
                     crc_ok <= (crc_sr == addr_sr[7:0]);
                  end
               end else begin
                  frame_err <= 1'b1;
               end
            end
         end
      end
   end

endmodule
